// File: rtl/simd_cell_pkg.sv
// simd_cell_pkg: shared dimensions, widths and element types for the
// temporal-LUT SIMD matrix-multiply cell.
//   Default dimensions : 3x3 input matrix times 3x3 weight matrix
//   Element widths     : 4-bit unsigned operands, 8-bit wrapped results
package simd_cell_pkg;

    localparam int DIM_ROW1_D     = 3;
    localparam int DIM_COL1_D     = 3;
    localparam int DIM_ROW2_D     = 3;
    localparam int DIM_COL2_D     = 3;
    localparam int INPUT_WIDTH_D  = 4;
    localparam int WEIGHT_WIDTH_D = 4;
    localparam int ACC_WIDTH_D    = 8;

    // The time counter shares the input width so that one sweep covers
    // every representable input value.
    localparam int CNT_W  = INPUT_WIDTH_D;
    localparam int PROD_W = INPUT_WIDTH_D + WEIGHT_WIDTH_D;
    localparam int SUM_W  = PROD_W + $clog2(DIM_COL1_D);

    typedef logic [INPUT_WIDTH_D-1:0]  in_t;
    typedef logic [WEIGHT_WIDTH_D-1:0] wt_t;
    typedef logic [PROD_W-1:0]         prod_t;
    typedef logic [ACC_WIDTH_D-1:0]    acc_t;

endpackage

// File: rtl/simd_cell_tlut_mul.sv
// tlut_mul: one temporal multiplier.
// Accumulates w once for every counter step 1..2^IW-1 that does not exceed a,
// so after a full sweep acc holds a*w.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : advance; all state holds when low
//   cap        : capture strobe (counter at 0), clears the accumulator
//   cnt        : shared time counter
//   a, w       : captured operands
//   acc        : running product
//   add_term   : this cycle's contribution (w or 0)
module tlut_mul #(
    parameter int INPUT_WIDTH  = 4,
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                enable,
    input  logic                                cap,
    input  logic [INPUT_WIDTH-1:0]              cnt,
    input  logic [INPUT_WIDTH-1:0]              a,
    input  logic [WEIGHT_WIDTH-1:0]             w,
    output logic [INPUT_WIDTH+WEIGHT_WIDTH-1:0] acc,
    output logic [WEIGHT_WIDTH-1:0]             add_term
);

    localparam int PW = INPUT_WIDTH + WEIGHT_WIDTH;

    // Step 0 is the capture slot and never contributes.
    always_comb begin
        add_term = '0;
        if (cnt != '0 && cnt <= a) begin
            add_term = w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (enable) begin
            if (cap) begin
                acc <= '0;
            end else begin
                acc <= acc + PW'(add_term);
            end
        end
    end

endmodule

// File: rtl/simd_cell.sv
// simd_cell: SIMD matrix-multiply compute tile for the temporal-LUT datapath.
// A shared counter sweeps 0..2^INPUT_WIDTH-1 on enabled cycles: step 0
// captures the operands, steps 1..15 drive the temporal multipliers, and the
// last step registers the summed products. One result matrix per 16 enabled
// cycles.
//   clk              : clock, rising edge
//   rst_n            : asynchronous active-low reset
//   enable           : advance; everything freezes when low
//   input_bin        : input matrix, element (r,c) at r*DIM_COL1+c
//   weight_bin       : weight matrix, element (r,c) at r*DIM_COL2+c
//   accumulated_mult : registered result, element (i,j) at i*DIM_COL2+j,
//                      wrapped modulo 2^ACC_WIDTH
module simd_cell
    import simd_cell_pkg::*;
#(
    parameter int DIM_ROW1     = DIM_ROW1_D,
    parameter int DIM_COL1     = DIM_COL1_D,
    parameter int DIM_ROW2     = DIM_ROW2_D,
    parameter int DIM_COL2     = DIM_COL2_D,
    parameter int INPUT_WIDTH  = INPUT_WIDTH_D,
    parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_D,
    parameter int ACC_WIDTH    = ACC_WIDTH_D
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             enable,
    input  logic [DIM_ROW1*DIM_COL1-1:0][INPUT_WIDTH-1:0]    input_bin,
    input  logic [DIM_ROW2*DIM_COL2-1:0][WEIGHT_WIDTH-1:0]   weight_bin,
    output logic [DIM_ROW1*DIM_COL2-1:0][ACC_WIDTH-1:0]      accumulated_mult
);

    localparam int PW  = INPUT_WIDTH + WEIGHT_WIDTH;
    localparam int SW  = PW + $clog2(DIM_COL1);
    localparam logic [INPUT_WIDTH-1:0] CNT_LAST = {INPUT_WIDTH{1'b1}};

    // Truncate the full-width tree sum to the output width (modulo wrap).
    function automatic logic [ACC_WIDTH-1:0] wrap_acc(input logic [SW-1:0] s);
        return ACC_WIDTH'(s);
    endfunction

    logic [INPUT_WIDTH-1:0]                            cnt;
    logic [DIM_ROW1*DIM_COL1-1:0][INPUT_WIDTH-1:0]     a_q;
    logic [DIM_ROW2*DIM_COL2-1:0][WEIGHT_WIDTH-1:0]    w_q;
    logic                                              cap;
    logic                                              last;

    logic [PW-1:0]           acc_w [DIM_ROW1][DIM_COL2][DIM_COL1];
    logic [WEIGHT_WIDTH-1:0] add_w [DIM_ROW1][DIM_COL2][DIM_COL1];

    assign cap  = enable && (cnt == '0);
    assign last = enable && (cnt == CNT_LAST);

    // Counter and operand capture; the counter wraps from the last step to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            a_q <= '0;
            w_q <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
            if (cap) begin
                a_q <= input_bin;
                w_q <= weight_bin;
            end
        end
    end

    // Temporal multipliers, one per (i,j,k) term of the product.
    for (genvar i = 0; i < DIM_ROW1; i++) begin : g_row
        for (genvar j = 0; j < DIM_COL2; j++) begin : g_col
            for (genvar k = 0; k < DIM_COL1; k++) begin : g_inner
                tlut_mul #(
                    .INPUT_WIDTH  (INPUT_WIDTH),
                    .WEIGHT_WIDTH (WEIGHT_WIDTH)
                ) u_mul (
                    .clk      (clk),
                    .rst_n    (rst_n),
                    .enable   (enable),
                    .cap      (cap),
                    .cnt      (cnt),
                    .a        (a_q[i*DIM_COL1+k]),
                    .w        (w_q[k*DIM_COL2+j]),
                    .acc      (acc_w[i][j][k]),
                    .add_term (add_w[i][j][k])
                );
            end

            // Adder tree: the final step's add term is folded in here so the
            // products are complete on the same edge that registers them.
            logic [SW-1:0] tree_sum;

            always_comb begin
                tree_sum = '0;
                for (int k = 0; k < DIM_COL1; k++) begin
                    tree_sum = tree_sum + SW'(acc_w[i][j][k]) + SW'(add_w[i][j][k]);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    accumulated_mult[i*DIM_COL2+j] <= '0;
                end else if (last) begin
                    accumulated_mult[i*DIM_COL2+j] <= wrap_acc(tree_sum);
                end
            end
        end
    end

endmodule

// File: tb/tb_simd_cell.sv
// Self-checking bench for simd_cell: directed table vectors, multi-cycle
// pause and mid-sweep reset sequences, and randomized sweeps checked against
// a plain matrix-multiply model.
module tb_simd_cell;
    import simd_cell_pkg::*;

    localparam int N = 3;

    typedef in_t  [N*N-1:0] in_arr_t;
    typedef wt_t  [N*N-1:0] wt_arr_t;
    typedef acc_t [N*N-1:0] out_arr_t;

    typedef struct {
        string    name;
        in_arr_t  a;
        wt_arr_t  w;
        out_arr_t exp;
    } vec_t;

    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    logic     enable = 1'b0;
    in_arr_t  input_bin = '0;
    wt_arr_t  weight_bin = '0;
    out_arr_t accumulated_mult;

    int       checks = 0;
    int       errors = 0;
    out_arr_t prev = '0;

    simd_cell dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .input_bin        (input_bin),
        .weight_bin       (weight_bin),
        .accumulated_mult (accumulated_mult)
    );

    always #5 clk = ~clk;

    // Reference: ordinary matrix product, wrapped to 8 bits.
    function automatic out_arr_t model(input in_arr_t a, input wt_arr_t w);
        out_arr_t r;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                int s = 0;
                for (int k = 0; k < N; k++) begin
                    s += int'(a[i*N+k]) * int'(w[k*N+j]);
                end
                r[i*N+j] = acc_t'(s % 256);
            end
        end
        return r;
    endfunction

    function automatic in_arr_t rand_in();
        in_arr_t r;
        for (int n = 0; n < N*N; n++) r[n] = in_t'($urandom_range(0, 15));
        return r;
    endfunction

    function automatic wt_arr_t rand_wt();
        wt_arr_t r;
        for (int n = 0; n < N*N; n++) r[n] = wt_t'($urandom_range(0, 15));
        return r;
    endfunction

    task automatic check_out(input string name, input out_arr_t exp);
        checks++;
        if (accumulated_mult !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, accumulated_mult, exp);
        end
    endtask

    task automatic check_cnt(input string name, input int exp);
        checks++;
        if (int'(dut.cnt) != exp) begin
            errors++;
            $display("FAIL %s: cnt got %0d expected %0d", name, dut.cnt, exp);
        end
    endtask

    // Full sweep starting with cnt==0; operands are scrambled after the
    // capture edge, and the output must stay put until the 16th edge.
    task automatic run_sweep(input string name, input in_arr_t a, input wt_arr_t w,
                             input out_arr_t exp);
        input_bin  = a;
        weight_bin = w;
        enable     = 1'b1;
        @(posedge clk);
        #1;
        input_bin  = rand_in();
        weight_bin = rand_wt();
        repeat (14) @(posedge clk);
        #1;
        check_out({name, "_hold"}, prev);
        @(posedge clk);
        #1;
        check_out(name, exp);
        prev = exp;
    endtask

    vec_t tbl[3];
    int   e0[9] = '{111, 90, 69, 66, 54, 42, 21, 18, 15};

    initial begin
        in_arr_t  pa;
        wt_arr_t  pw;
        out_arr_t pexp;

        for (int n = 0; n < N*N; n++) begin
            tbl[0].a[n] = in_t'(8 - n);  tbl[0].w[n] = wt_t'(8 - n);  tbl[0].exp[n] = acc_t'(e0[n]);
            tbl[1].a[n] = in_t'(4);      tbl[1].w[n] = wt_t'(1);      tbl[1].exp[n] = acc_t'(12);
            tbl[2].a[n] = in_t'(15);     tbl[2].w[n] = wt_t'(15);     tbl[2].exp[n] = acc_t'(163);
        end
        tbl[0].name = "desc";
        tbl[1].name = "all4x1";
        tbl[2].name = "all15";

        // Reset held with enable high and changing operands.
        enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            input_bin  = rand_in();
            weight_bin = rand_wt();
            @(posedge clk);
            #1;
            check_out("reset_out", '0);
            check_cnt("reset_cnt", 0);
        end
        rst_n = 1'b1;

        // Directed table.
        for (int t = 0; t < 3; t++) begin
            run_sweep(tbl[t].name, tbl[t].a, tbl[t].w, tbl[t].exp);
        end

        // Pause mid-sweep for 7 cycles while operands change.
        pa = rand_in();
        pw = rand_wt();
        pexp = model(pa, pw);
        input_bin  = pa;
        weight_bin = pw;
        enable     = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        enable = 1'b0;
        for (int c = 0; c < 7; c++) begin
            input_bin  = rand_in();
            weight_bin = rand_wt();
            @(posedge clk);
            #1;
        end
        check_cnt("pause_cnt", 5);
        check_out("pause_hold", prev);
        enable = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_out("resume_hold", prev);
        @(posedge clk);
        #1;
        check_out("resume_result", pexp);
        prev = pexp;

        // Reset asserted at cnt==8, then a clean sweep.
        input_bin  = rand_in();
        weight_bin = rand_wt();
        repeat (8) @(posedge clk);
        #1;
        check_cnt("pre_reset_cnt", 8);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("midreset_out", '0);
        check_cnt("midreset_cnt", 0);
        prev = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pa = rand_in();
        pw = rand_wt();
        run_sweep("after_reset", pa, pw, model(pa, pw));

        // Randomized sweeps, with a boundary pair mixed in.
        for (int r = 0; r < 12; r++) begin
            pa = rand_in();
            pw = rand_wt();
            if (r == 5) begin
                pa = '0;
            end
            run_sweep("random", pa, pw, model(pa, pw));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
